// File: rtl/apb_slave_regfile.sv
// APB completer with a small register file and a fixed number of wait states.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transfer in progress; setup phase latches the request
// WAIT  | access phase, PREADY low, counting down the wait states
// DONE  | PREADY high for one cycle; a write commits at the edge after
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        WS      = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic                  setup;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic                  write_sel;
    logic                  err_sel;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic                  commit;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        setup   = PSEL && !PENABLE;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response source: with zero wait states DONE is entered straight from
    // the setup edge, before the latched copies exist, so use the bus there.
    always_comb begin
        addr_sel  = (state_q == IDLE) ? PADDR  : addr_q;
        write_sel = (state_q == IDLE) ? PWRITE : write_q;
        err_sel   = ({1'b0, addr_sel} >= DEPTH_W);
        rdata_sel = '0;
        if (!write_sel && !err_sel) begin
            rdata_sel = regs[addr_sel[IDX_W-1:0]];
        end
        commit    = (state_q == DONE) && write_q && !PSLVERR;
    end

    // State, request latches and registered response outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && setup) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
            end
            PREADY  <= (state_d == DONE);
            PSLVERR <= (state_d == DONE) && err_sel;
            PRDATA  <= (state_d == DONE) ? rdata_sel : '0;
        end
    end

    // Register file; a write lands at the edge that ends DONE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: a two-wait-state instance and a zero-wait
// instance share the bus; a scoreboard monitor checks each completion.
module tb_apb_slave_regfile;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic [7:0] rdata2, rdata0;
    logic       rdy2, rdy0, err2, err0;

    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(rdata2), .PREADY(rdy2), .PSLVERR(err2)
    );

    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(rdata0), .PREADY(rdy0), .PSLVERR(err0)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic tgt = 1'b0;   // 0 = two-wait instance, 1 = zero-wait instance

    logic       m_ready, m_err;
    logic [7:0] m_rdata;
    assign m_ready = tgt ? rdy0   : rdy2;
    assign m_err   = tgt ? err0   : err2;
    assign m_rdata = tgt ? rdata0 : rdata2;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Monitor: every completion on the watched instance must match the head.
    always @(negedge PCLK) begin
        exp_t e;
        if (m_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pready cyc=%0d got PREADY=1 required 0", cyc);
            end else begin
                e = sb.pop_front();
                if (m_rdata !== e.rdata || m_err !== e.err || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL xfer cyc got %0d req %0d, PRDATA got %02h req %02h, PSLVERR got %0b req %0b",
                             cyc, e.cyc, m_rdata, e.rdata, m_err, e.err);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
        end
    endtask

    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] exp_rd, input logic exp_err, input int ws,
                        input bit rst_in_done);
        exp_t e;
        int   k;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        e.cyc   = cyc + 1 + ws;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR   = ~addr;
        PWDATA  = ~data;
        k = 0;
        while (!m_ready && k < 20) begin
            @(posedge PCLK); #1;
            k++;
        end
        if (!m_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout addr=%02h got no PREADY required PREADY within 20 cycles", addr);
        end
        if (rst_in_done) PRESET = 1'b1;
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        if (rst_in_done) begin
            n_vec++;
            if (rdy2 !== 1'b0 || err2 !== 1'b0 || rdata2 !== 8'h00) begin
                n_err++;
                $display("FAIL reset_in_done got PREADY=%0b PSLVERR=%0b PRDATA=%02h required 0/0/00",
                         rdy2, err2, rdata2);
            end
            PRESET = 1'b0;
        end
    endtask

    initial begin
        PRESET  = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 8'h00;
        PWDATA  = 8'h00;
        idle(2);
        PRESET = 1'b0;

        n_vec++;
        if (rdy2 !== 1'b0 || err2 !== 1'b0 || rdata2 !== 8'h00 ||
            rdy0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs got %0b/%0b/%02h %0b/%0b/%02h required all 0",
                     rdy2, err2, rdata2, rdy0, err0, rdata0);
        end

        // reads after reset
        xfer(1'b0, 8'd0,  8'h00, 8'h00, 1'b0, 2, 1'b0);
        xfer(1'b0, 8'd5,  8'h00, 8'h00, 1'b0, 2, 1'b0);
        xfer(1'b0, 8'd15, 8'h00, 8'h00, 1'b0, 2, 1'b0);

        // write then back-to-back read
        xfer(1'b1, 8'd3, 8'hA5, 8'h00, 1'b0, 2, 1'b0);
        xfer(1'b0, 8'd3, 8'h00, 8'hA5, 1'b0, 2, 1'b0);
        xfer(1'b0, 8'd4, 8'h00, 8'h00, 1'b0, 2, 1'b0);

        // out of range
        xfer(1'b1, 8'h20, 8'h5A, 8'h00, 1'b1, 2, 1'b0);
        xfer(1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 2, 1'b0);
        xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 2, 1'b0);
        xfer(1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 8'(i), 8'h00, (i == 3) ? 8'hA5 : 8'h00, 1'b0, 2, 1'b0);
        end

        // abort: drop PSEL in the second WAIT cycle, no completion expected
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd7; PWDATA = 8'hFF;
        idle(1);
        PENABLE = 1'b1;
        idle(1);
        PSEL = 1'b0; PENABLE = 1'b0;
        idle(4);
        xfer(1'b0, 8'd7, 8'h00, 8'h00, 1'b0, 2, 1'b0);

        // zero wait states on the second instance
        idle(2);
        tgt = 1'b1;
        xfer(1'b1, 8'd0, 8'h11, 8'h00, 1'b0, 0, 1'b0);
        xfer(1'b0, 8'd0, 8'h00, 8'h11, 1'b0, 0, 1'b0);
        xfer(1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 0, 1'b0);
        idle(3);
        tgt = 1'b0;
        idle(1);

        // reset during DONE of a write
        xfer(1'b1, 8'd2, 8'h3C, 8'h00, 1'b0, 2, 1'b1);
        idle(1);
        xfer(1'b0, 8'd2, 8'h00, 8'h00, 1'b0, 2, 1'b0);
        xfer(1'b0, 8'd3, 8'h00, 8'h00, 1'b0, 2, 1'b0);

        idle(5);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expect got %0d pending required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) holding a small register file, built as the responder end of the team's APB master on the same bus. It decodes PSEL/PENABLE/PWRITE/PADDR, inserts a fixed number of wait states via PREADY, commits writes, returns read data on PRDATA and flags out-of-range addresses on PSLVERR. It sits behind the master as the default register target in bus-level tests and SoC integration.

## Interface

- ADDR_WIDTH, 8, PADDR width
- DATA_WIDTH, 8, PWDATA/PRDATA width and register width
- DEPTH, 16, number of registers; valid addresses are 0..DEPTH-1; DEPTH ≤ 2^ADDR_WIDTH
- WAIT_STATES, 2, access-phase cycles with PREADY=0 before completion; legal range 0..15
- PCLK  in  1  clock; all state changes on the rising edge
- PRESET  in  1  reset; one clock, reset is synchronous and active-high
- PSEL  in  1  slave select from master
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  transfer address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, valid only while PREADY=1
- PREADY  out  1  transfer completion, registered
- PSLVERR  out  1  error response, valid only while PREADY=1

## Operation

- FSM states: IDLE, WAIT, DONE. Reset (PRESET=1 at an edge) forces IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, all DEPTH registers=0.
- IDLE: outputs 0. At an edge with PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA, and load the counter with WAIT_STATES.
  - If WAIT_STATES=0, go to DONE.
  - Otherwise go to WAIT.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT: PREADY=0. Each edge with PSEL=1 decrements the counter.
  - When the counter is 1 at the edge, go to DONE.
  - If PSEL=0 at an edge (abort), go to IDLE. No write is performed.
- DONE: PREADY=1 for exactly one cycle. Let err = latched address ≥ DEPTH.
  - PSLVERR=err.
  - PRDATA = reg[latched address] for a read with err=0; otherwise 0.
  - At the edge leaving DONE, a write with err=0 updates reg[latched address] with the latched PWDATA. An errored write changes nothing.
  - DONE always returns to IDLE.
- Back-to-back transfers: the master's next setup phase coincides with the slave's IDLE cycle after DONE, so consecutive transfers need no dead cycle.
- Read-after-write to the same address in the next transfer returns the new value.
- PADDR/PWDATA changes after setup are ignored; the slave uses only the latched copies.
- Address comparison is unsigned and done at full ADDR_WIDTH, with no wrap or aliasing.

## Timing

- Cycle S = master setup phase. The first access cycle is S+1.
- PREADY=1 in cycle S+1+WAIT_STATES. The transfer occupies 2+WAIT_STATES cycles in total.
- PREADY, PSLVERR and PRDATA are registered and change only on PCLK edges. There is no combinational path from any input to any output.
- Write data becomes visible in registers at the edge ending the DONE cycle.
- PRESET asserted mid-transfer (WAIT or DONE):
  - the next edge goes to IDLE with all outputs 0;
  - the in-flight write is dropped;
  - all registers are cleared.
- PRESET has priority over every other event at the same edge.

## Test plan

- Reset: hold PRESET 2 cycles, then read addresses 0, 5 and 15 → PRDATA=0x00, PSLVERR=0, PREADY high exactly 3 cycles after each setup (WAIT_STATES=2).
- Write/read: write 0xA5 to address 3, then read address 3 back-to-back → read returns 0xA5 and PSLVERR=0. Each transfer takes 4 cycles; address 4 still reads 0x00.
- Out of range (DEPTH=16): write 0x5A to address 0x20, then read 0x20 → both complete with PSLVERR=1 and PRDATA=0x00. A full read sweep of 0..15 is unchanged.
- Zero wait states (WAIT_STATES=0): write 0x11 to address 0, then read it → PREADY=1 in the first access cycle and read returns 0x11.
- Abort: start a write of 0xFF to address 7 and drop PSEL during WAIT → slave returns to IDLE with PREADY never asserted. A later read of address 7 returns its prior value 0x00.
- Reset mid-transfer: assert PRESET in the DONE cycle of a write of 0x3C to address 2 → outputs 0 next cycle, and a later read of address 2 returns 0x00.
